// File: rtl/ysyx_25040111_memarb_pkg.sv
// Shared encodings for the icache/data memory arbiter: FSM states, owner IDs and
// the LSU size codes carried on m_mask.
package ysyx_25040111_memarb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIfetch = 2'd1,
    StDload  = 2'd2,
    StDstore = 2'd3
  } state_e;

  localparam logic OwnerIc = 1'b0;
  localparam logic OwnerD  = 1'b1;

  localparam logic [1:0] MaskByte = 2'd0;
  localparam logic [1:0] MaskHalf = 2'd1;
  localparam logic [1:0] MaskWord = 2'd2;

  localparam int unsigned WdWidth = 10;

endpackage

// File: rtl/ysyx_25040111_memarb_rr2.sv
// Two-way round-robin picker; on a tie the requester not granted last wins.
module ysyx_25040111_rr2
  import ysyx_25040111_memarb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req_ic,
  input  logic       req_d,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (req_ic && req_d) begin
      grant = (last_grant == OwnerD) ? 2'b01 : 2'b10;
    end else if (req_ic) begin
      grant = 2'b01;
    end else if (req_d) begin
      grant = 2'b10;
    end
  end

  // grant[1] doubles as the owner ID of the winner (IC = 0, D = 1).
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= OwnerD;
    end else if (update && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/ysyx_25040111_memarb.sv
// Arbitrates the icache refill and data paths onto the single LSU port, holds the
// grant for a whole burst and routes response beats back to the owner.
module ysyx_25040111_memarb
  import ysyx_25040111_memarb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ic_valid,
  output logic        ic_ready,
  input  logic [31:0] ic_addr,
  input  logic [7:0]  ic_len,
  output logic        ic_rvalid,
  output logic [31:0] ic_rdata,
  output logic        ic_rlast,
  output logic        ic_err,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_mask,
  input  logic        d_rsign,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_mask,
  output logic        m_rsign,
  output logic [7:0]  m_len,
  output logic        m_burst,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rerr
);

  localparam logic [WdWidth-1:0] TimeoutCnt = WdWidth'(TIMEOUT);

  state_e             state;
  logic [7:0]         beats;
  logic [WdWidth-1:0] wd;
  logic [1:0]         grant;
  logic               idle, hs, last_cnt, fire, rv, err, d_busy;

  assign idle = (state == StIdle);

  ysyx_25040111_rr2 u_rr2 (
    .clock  (clock),
    .reset  (reset),
    .req_ic (ic_valid & idle),
    .req_d  (d_valid & idle),
    .update (hs),
    .grant  (grant)
  );

  always_comb begin
    m_valid  = 1'b0;
    m_write  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_mask   = '0;
    m_rsign  = 1'b0;
    m_len    = '0;
    m_burst  = 1'b0;
    ic_ready = 1'b0;
    d_ready  = 1'b0;
    if (grant[0]) begin
      m_valid  = 1'b1;
      m_addr   = ic_addr;
      m_mask   = MaskWord;
      m_len    = ic_len;
      m_burst  = (ic_len != 8'd0);
      ic_ready = m_ready;
    end else if (grant[1]) begin
      m_valid = 1'b1;
      m_write = d_write;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_mask  = d_mask;
      m_rsign = d_rsign;
      d_ready = m_ready;
    end
  end

  assign hs       = m_valid & m_ready;
  assign last_cnt = (beats == 8'd0);
  // A real beat in the timeout cycle wins over the forced termination.
  assign fire     = ~idle & ~m_rvalid & (wd == TimeoutCnt);
  assign rv       = (~idle & m_rvalid) | fire;
  assign err      = fire | m_rerr | (m_rlast != last_cnt);
  assign d_busy   = (state == StDload) || (state == StDstore);

  assign ic_rvalid = (state == StIfetch) & rv;
  assign ic_rdata  = (ic_rvalid & ~fire) ? m_rdata : 32'd0;
  assign ic_rlast  = ic_rvalid & (fire | last_cnt);
  assign ic_err    = ic_rvalid & err;
  assign d_rvalid  = d_busy & rv;
  assign d_rdata   = (d_rvalid & ~fire) ? m_rdata : 32'd0;
  assign d_err     = d_rvalid & err;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= StIdle;
      beats <= '0;
      wd    <= '0;
    end else if (idle) begin
      if (hs) begin
        wd <= '0;
        if (grant[0]) begin
          state <= StIfetch;
          beats <= ic_len;
        end else begin
          state <= d_write ? StDstore : StDload;
          beats <= '0;
        end
      end
    end else if (m_rvalid) begin
      wd <= '0;
      if (last_cnt || m_rlast) begin
        state <= StIdle;
        beats <= '0;
      end else begin
        beats <= beats - 8'd1;
      end
    end else if (fire) begin
      state <= StIdle;
      beats <= '0;
      wd    <= '0;
    end else begin
      wd <= wd + 1'b1;
    end
  end

endmodule
